openofdm_rx_byte_packer: RTL

Downstream stage of the OFDM receive core. It collects the decoded PSDU byte stream (`byte_out`/`byte_out_strobe`), packs it little-endian into 64-bit words, and tags the final word of each packet with the FCS result. Words are buffered in a small FIFO and presented on an AXI-Stream master toward the rx DMA interface. Packet framing and error status travel with the data, so the consumer needs no side-band timing.

---
 rtl/openofdm_rx_pkg.sv | 25 ++
 rtl/rx_word_fifo.sv | 63 ++++++
 rtl/openofdm_rx_byte_packer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/openofdm_rx_pkg.sv
// Shared types and constants for the OFDM rx byte packer and its word FIFO.
package openofdm_rx_pkg;

   localparam int unsigned WORD_W      = 64;
   localparam int unsigned KEEP_W      = 8;
   localparam int unsigned USER_W      = 2;
   localparam int unsigned USER_FCS_OK = 0;
   localparam int unsigned USER_ERR    = 1;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StPack    = 2'd1,
      StWaitFcs = 2'd2,
      StFlush   = 2'd3
   } packer_state_e;

   // One FIFO entry: 2 user + 1 last + 8 keep + 64 data = 75 bits.
   typedef struct packed {
      logic [USER_W-1:0] user;
      logic              last;
      logic [KEEP_W-1:0] keep;
      logic [WORD_W-1:0] data;
   } rx_word_t;

endpackage

// File: rtl/rx_word_fifo.sv
// Show-ahead word FIFO with exact full flag and a registered AXI-Stream style output.
module rx_word_fifo
   import openofdm_rx_pkg::*;
#(
   parameter int unsigned DepthLog2 = 4
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  logic     wr_en_i,
   input  rx_word_t wr_word_i,
   output logic     full_o,
   output rx_word_t rd_word_o,
   output logic     rd_valid_o,
   input  logic     rd_ready_i
);

   localparam int unsigned Depth = 2 ** DepthLog2;
   localparam logic [DepthLog2:0] FullLevel = (DepthLog2 + 1)'(Depth);

   rx_word_t             mem_q [Depth];
   logic [DepthLog2:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DepthLog2:0]   level;
   logic                 pop, push;
   rx_word_t             out_q, out_d;
   logic                 valid_q, valid_d;

   always_comb begin
      level    = wr_ptr_q - rd_ptr_q;
      full_o   = (level == FullLevel);
      pop      = valid_q & rd_ready_i;
      // A push into a full FIFO is fine when the head leaves in the same cycle.
      push     = wr_en_i & (~full_o | pop);
      rd_ptr_d = rd_ptr_q + {{DepthLog2{1'b0}}, pop};
      wr_ptr_d = wr_ptr_q + {{DepthLog2{1'b0}}, push};
      // Compare against the committed write pointer: a fresh entry shows one cycle later.
      valid_d  = (wr_ptr_q != rd_ptr_d);
      out_d    = valid_d ? mem_q[rd_ptr_d[DepthLog2-1:0]] : '0;
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q[DepthLog2-1:0]] <= wr_word_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         out_q    <= '0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         out_q    <= out_d;
         valid_q  <= valid_d;
      end
   end

   assign rd_word_o  = out_q;
   assign rd_valid_o = valid_q;

endmodule

// File: rtl/openofdm_rx_byte_packer.sv
// Packs decoded PSDU bytes little-endian into 64-bit words, tags the last word with FCS/error
// status and streams the words out through a small FIFO.
module openofdm_rx_byte_packer
   import openofdm_rx_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
   input  logic                s00_axi_aclk,
   input  logic                s00_axi_aresetn,
   input  logic                pkt_header_valid_strobe,
   input  logic [15:0]         pkt_len,
   input  logic                byte_out_strobe,
   input  logic [7:0]          byte_out,
   input  logic                fcs_out_strobe,
   input  logic                fcs_ok,
   output logic [WORD_W-1:0]   m_axis_tdata,
   output logic [KEEP_W-1:0]   m_axis_tkeep,
   output logic                m_axis_tlast,
   output logic [USER_W-1:0]   m_axis_tuser,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   output logic [15:0]         overflow_cnt,
   output logic [1:0]          packer_state
);

   packer_state_e       state_q, state_d;
   logic [2:0]          lane_q, lane_d;
   logic [15:0]         cnt_q, cnt_d, len_q, len_d;
   logic [15:0]         pend_len_q, pend_len_d, ovf_q, ovf_d;
   logic                err_q, err_d, pend_valid_q, pend_valid_d, pend_err_q, pend_err_d;
   logic [WORD_W-1:0]   data_q, data_d;
   logic [KEEP_W-1:0]   keep_q, keep_d;
   logic [USER_W-1:0]   user_q, user_d;

   logic                push, fifo_full, fifo_can_push, abort;
   rx_word_t            push_word, out_word;
   logic                start_pkt, start_err, ovf_inc;
   logic [15:0]         start_len;

   assign fifo_can_push = ~fifo_full | (m_axis_tvalid & m_axis_tready);
   assign abort = pkt_header_valid_strobe & ((state_q == StPack) | (state_q == StWaitFcs));

   always_comb begin
      state_d      = state_q;
      lane_d       = lane_q;
      cnt_d        = cnt_q;
      len_d        = len_q;
      err_d        = err_q;
      data_d       = data_q;
      keep_d       = keep_q;
      user_d       = user_q;
      pend_valid_d = pend_valid_q;
      pend_len_d   = pend_len_q;
      pend_err_d   = pend_err_q;
      ovf_d        = ovf_q;
      push         = 1'b0;
      push_word    = '0;
      start_pkt    = 1'b0;
      start_len    = '0;
      start_err    = 1'b0;
      ovf_inc      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (pkt_header_valid_strobe && pkt_len != 16'd0) begin
               start_pkt = 1'b1;
               start_len = pkt_len;
            end
         end
         StPack: begin
            if (!abort && byte_out_strobe) begin
               data_d[{lane_q, 3'b000} +: 8] = byte_out;
               keep_d[lane_q] = 1'b1;
               lane_d = lane_q + 3'd1;
               cnt_d  = cnt_q + 16'd1;
               if (cnt_d == len_q) begin
                  if (fcs_out_strobe) begin
                     user_d[USER_FCS_OK] = fcs_ok;
                     user_d[USER_ERR]    = err_q;
                     state_d = StFlush;
                  end else begin
                     state_d = StWaitFcs;
                  end
               end else if (lane_q == 3'd7) begin
                  push      = 1'b1;
                  push_word = '{user: '0, last: 1'b0, keep: keep_d, data: data_d};
                  if (!fifo_can_push) begin
                     err_d   = 1'b1;
                     ovf_inc = 1'b1;
                  end
                  data_d = '0;
                  keep_d = '0;
               end
            end
         end
         StWaitFcs: begin
            if (!abort && fcs_out_strobe) begin
               user_d[USER_FCS_OK] = fcs_ok;
               user_d[USER_ERR]    = err_q;
               state_d = StFlush;
            end
         end
         StFlush: begin
            push      = 1'b1;
            push_word = '{user: user_q, last: 1'b1, keep: keep_q, data: data_q};
            // Bytes here belong to a packet whose header we already queued; they are lost.
            if (byte_out_strobe) begin
               ovf_inc    = 1'b1;
               pend_err_d = 1'b1;
            end
            if (pkt_header_valid_strobe) begin
               pend_valid_d = (pkt_len != 16'd0);
               pend_len_d   = pkt_len;
               pend_err_d   = 1'b0;
            end
            if (fifo_can_push) begin
               state_d      = StIdle;
               pend_valid_d = 1'b0;
               if (pkt_header_valid_strobe) begin
                  start_pkt = (pkt_len != 16'd0);
                  start_len = pkt_len;
               end else if (pend_valid_q) begin
                  start_pkt = 1'b1;
                  start_len = pend_len_q;
                  start_err = pend_err_q | byte_out_strobe;
               end
            end
         end
      endcase

      // Header mid-packet: close what we have as an errored last word and queue the new one.
      if (abort) begin
         user_d             = '0;
         user_d[USER_ERR]   = 1'b1;
         state_d            = StFlush;
         pend_valid_d       = (pkt_len != 16'd0);
         pend_len_d         = pkt_len;
         pend_err_d         = 1'b0;
      end

      if (start_pkt) begin
         state_d = StPack;
         len_d   = start_len;
         lane_d  = '0;
         cnt_d   = '0;
         err_d   = start_err;
         data_d  = '0;
         keep_d  = '0;
         user_d  = '0;
      end

      if (ovf_inc && ovf_q != 16'hFFFF) begin
         ovf_d = ovf_q + 16'd1;
      end
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         state_q      <= StIdle;
         lane_q       <= '0;
         cnt_q        <= '0;
         len_q        <= '0;
         err_q        <= 1'b0;
         data_q       <= '0;
         keep_q       <= '0;
         user_q       <= '0;
         pend_valid_q <= 1'b0;
         pend_len_q   <= '0;
         pend_err_q   <= 1'b0;
         ovf_q        <= '0;
      end else begin
         state_q      <= state_d;
         lane_q       <= lane_d;
         cnt_q        <= cnt_d;
         len_q        <= len_d;
         err_q        <= err_d;
         data_q       <= data_d;
         keep_q       <= keep_d;
         user_q       <= user_d;
         pend_valid_q <= pend_valid_d;
         pend_len_q   <= pend_len_d;
         pend_err_q   <= pend_err_d;
         ovf_q        <= ovf_d;
      end
   end

   rx_word_fifo #(
      .DepthLog2 (FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clk_i      (s00_axi_aclk),
      .rst_ni     (s00_axi_aresetn),
      .wr_en_i    (push),
      .wr_word_i  (push_word),
      .full_o     (fifo_full),
      .rd_word_o  (out_word),
      .rd_valid_o (m_axis_tvalid),
      .rd_ready_i (m_axis_tready)
   );

   assign m_axis_tdata = out_word.data;
   assign m_axis_tkeep = out_word.keep;
   assign m_axis_tlast = out_word.last;
   assign m_axis_tuser = out_word.user;
   assign overflow_cnt = ovf_q;
   assign packer_state = state_q;

endmodule
